// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: field widths, special encodings and operand classification.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [31:0]      QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp32_class_t;

  // Exponent zero counts as zero whatever the fraction, so subnormals flush here.
  function automatic fp32_class_t classify(input fp32_t x);
    fp32_class_t c;
    c.is_zero = (x.exp == '0);
    c.is_inf  = (x.exp == EXP_MAX) && (x.frac == '0);
    c.is_nan  = (x.exp == EXP_MAX) && (x.frac != '0);
    return c;
  endfunction

endpackage

// File: rtl/fp32_mant_mul.sv
// Unsigned 24x24 significand multiplier producing the full 48-bit product.
module fp32_mant_mul
  import fp32_pkg::*;
(
  input  logic [SIG_W-1:0]  a,
  input  logic [SIG_W-1:0]  b,
  output logic [PROD_W-1:0] product
);

  assign product = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/floating_point_multiplier.sv
// Two-stage binary32 multiplier, round-to-nearest-even, subnormals flushed to zero.
module floating_point_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  output logic [31:0] Product
);

  fp32_t             op_a, op_b;
  fp32_class_t       cls_a, cls_b;
  logic [SIG_W-1:0]  sig_a, sig_b;
  logic [PROD_W-1:0] mant_prod;
  logic signed [9:0] exp_sum;
  logic              spec_nan, spec_inf, spec_zero;

  assign op_a  = A;
  assign op_b  = B;
  assign cls_a = classify(op_a);
  assign cls_b = classify(op_b);
  assign sig_a = {1'b1, op_a.frac};
  assign sig_b = {1'b1, op_b.frac};

  assign exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                 - $signed({2'b00, EXP_BIAS});

  // Special-case priority is resolved here; stage 2 only checks the flags in order.
  assign spec_nan  = cls_a.is_nan | cls_b.is_nan
                   | (cls_a.is_inf & cls_b.is_zero) | (cls_a.is_zero & cls_b.is_inf);
  assign spec_inf  = cls_a.is_inf | cls_b.is_inf;
  assign spec_zero = cls_a.is_zero | cls_b.is_zero;

  fp32_mant_mul u_mant_mul (
    .a       (sig_a),
    .b       (sig_b),
    .product (mant_prod)
  );

  logic              s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [9:0] s1_exp;
  logic [PROD_W-1:0] s1_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= op_a.sign ^ op_b.sign;
        s1_nan  <= spec_nan;
        s1_inf  <= spec_inf;
        s1_zero <= spec_zero;
        s1_exp  <= exp_sum;
        s1_prod <= mant_prod;
      end
    end
  end

  logic signed [9:0]  norm_exp, final_exp;
  logic [FRAC_W-1:0]  mant;
  logic               guard, sticky, round_up;
  logic [SIG_W-1:0]   rounded;
  logic [31:0]        result;

  always_comb begin
    norm_exp = s1_exp;
    mant     = s1_prod[45:23];
    guard    = s1_prod[22];
    sticky   = |s1_prod[21:0];
    if (s1_prod[47]) begin
      norm_exp = s1_exp + 10'sd1;
      mant     = s1_prod[46:24];
      guard    = s1_prod[23];
      sticky   = |s1_prod[22:0];
    end
    round_up = guard & (sticky | mant[0]);
    rounded  = {1'b0, mant} + {{FRAC_W{1'b0}}, round_up};
    // A carry out of rounding leaves the fraction all zeros, so only the exponent moves.
    final_exp = norm_exp + $signed({9'b0, rounded[FRAC_W]});

    if (s1_nan)
      result = QNAN;
    else if (s1_inf)
      result = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
    else if (s1_zero)
      result = {s1_sign, 31'h0};
    else if (final_exp >= 10'sd255)
      result = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
    else if (final_exp <= 10'sd0)
      result = {s1_sign, 31'h0};
    else
      result = {s1_sign, final_exp[EXP_W-1:0], rounded[FRAC_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Product   <= 32'h0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid)
        Product <= result;
    end
  end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Directed self-checking bench: expected products queued at drive time, compared on output.
module tb_floating_point_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A, B;
  logic        out_valid;
  logic [31:0] Product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] valid_pipe;
  bit         monitor_on = 1'b0;

  floating_point_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Product   (Product)
  );

  always #5 clk = ~clk;

  // Two-cycle latency reference for out_valid, cleared by reset like the pipeline.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_pipe <= 2'b00;
    else        valid_pipe <= {valid_pipe[0], in_valid};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected);
    exp_t e;
    e.tag   = tag;
    e.value = expected;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: checks valid timing every cycle and pops the scoreboard on each result.
  always @(negedge clk) begin
    if (monitor_on && rst_n) begin
      checkOutput("out_valid_timing", {31'b0, out_valid}, {31'b0, valid_pipe[1]});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpected_output observed=%h expected=none", Product);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput(e.tag, Product, e.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    A        = 32'h0;
    B        = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_product", Product, 32'h0);
    checkOutput("reset_valid", {31'b0, out_valid}, 32'h0);
    rst_n      = 1'b1;
    monitor_on = 1'b1;
    idle(1);

    $display("[TB] back-to-back basic vectors");
    applyStimulus("v1_5.25x2.2",    32'h40A80000, 32'h400CCCCD, 32'h4138CCCD);
    applyStimulus("v2_-0.3x500.25", 32'hBE99999A, 32'h43FA2000, 32'hC3161334);
    applyStimulus("v3_+0x5.25",     32'h00000000, 32'h40A80000, 32'h00000000);
    applyStimulus("v3_-0x5.25",     32'h80000000, 32'h40A80000, 32'h80000000);
    applyStimulus("v4_5.25x-2.2",   32'h40A80000, 32'hC00CCCCD, 32'hC138CCCD);
    idle(4);
    checkOutput("hold_product", Product, 32'hC138CCCD);

    $display("[TB] special cases and boundaries");
    applyStimulus("inf_x_zero",      32'h7F800000, 32'h00000000, 32'h7FC00000);
    applyStimulus("nan_x_one",       32'h7FC00000, 32'h3F800000, 32'h7FC00000);
    applyStimulus("nan_x_zero",      32'h7F800001, 32'h00000000, 32'h7FC00000);
    applyStimulus("negzero_x_neginf",32'h80000000, 32'hFF800000, 32'h7FC00000);
    applyStimulus("subnorm_x_inf",   32'h00000001, 32'h7F800000, 32'h7FC00000);
    applyStimulus("neginf_x_two",    32'hFF800000, 32'h40000000, 32'hFF800000);
    applyStimulus("1e38_squared",    32'h7E967699, 32'h7E967699, 32'h7F800000);
    applyStimulus("exp_hits_255",    32'h7F000000, 32'h40000000, 32'h7F800000);
    applyStimulus("1e-38_squared",   32'h006CE3EE, 32'h006CE3EE, 32'h00000000);
    applyStimulus("exp_hits_0",      32'h20000000, 32'h1F800000, 32'h00000000);
    applyStimulus("neg_exp_hits_0",  32'hA0000000, 32'h1F800000, 32'h80000000);
    applyStimulus("min_normal",      32'h20000000, 32'h20000000, 32'h00800000);
    applyStimulus("one_x_one",       32'h3F800000, 32'h3F800000, 32'h3F800000);
    applyStimulus("round_carry",     32'h3FCA6691, 32'h3FA1E58F, 32'h40000000);
    applyStimulus("sticky_no_round", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000);
    applyStimulus("bit47_trunc",     32'h3FFFFFFF, 32'h3F7FFFFF, 32'h3FFFFFFE);
    idle(4);

    $display("[TB] reset mid-stream");
    applyStimulus("pre_reset_a", 32'h40A80000, 32'h400CCCCD, 32'h4138CCCD);
    applyStimulus("pre_reset_b", 32'hBE99999A, 32'h43FA2000, 32'hC3161334);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midreset_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("midreset_product", Product, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    checkOutput("no_stale_product", Product, 32'h0);
    applyStimulus("post_reset", 32'h40A80000, 32'hC00CCCCD, 32'hC138CCCD);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("[TB] FAIL drain observed=%0d pending expected=0 pending", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
